// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator driven by one shared period counter.
// Edge-aligned (mode 0) or center-aligned (mode 1) operation, with duty
// adjustment through debounced inc/dec buttons that target the channel on
// ch_sel. Duty changes and mode changes are staged and only take effect at a
// period boundary, so a period in progress is never disturbed.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   btn_inc       raw increase button (asynchronous to nothing, just bouncy)
//   btn_dec       raw decrease button
//   ch_sel        channel addressed by button events
//   mode          0 = edge-aligned, 1 = center-aligned (latched at boundary)
//   pwm_out       registered PWM outputs, one per channel
//   duty_o        pending duty of the channel on ch_sel, 0 if out of range
//   period_start  one-cycle pulse aligned with the first pwm_out cycle of
//                 each period
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pwm_channel
//
// Per-channel state: pending duty (button target), active duty (used by the
// comparator) and the registered PWM output bit.
//
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   inc, dec   single-cycle button events already qualified by channel select
//   boundary   last cycle of the current period; copies pending -> active
//   cnt        shared period counter
//   pending    staged duty value
//   pwm        registered output, high while cnt < active
// ---------------------------------------------------------------------------
module pwm_channel #(
    parameter int CNT_W      = 4,
    parameter int PERIOD     = 10,
    parameter int DUTY_RESET = 5,
    parameter int STEP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             boundary,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] pending,
    output logic             pwm
);

    // Saturation arithmetic is done one bit wider than the duty so that the
    // overflow past PERIOD and the underflow below 0 are both visible.
    localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] PER_N  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] RST_N  = CNT_W'(DUTY_RESET);

    logic [CNT_W-1:0] active;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] inc_val;
    logic [CNT_W-1:0] dec_val;

    always_comb begin
        sum     = {1'b0, pending} + STEP_X;
        diff    = {1'b0, pending} - STEP_X;
        inc_val = (sum > PER_X) ? PER_N : sum[CNT_W-1:0];
        dec_val = ({1'b0, pending} < STEP_X) ? '0 : diff[CNT_W-1:0];
    end

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= RST_N;
        end else if (inc && !dec) begin
            pending <= inc_val;
        end else if (dec && !inc) begin
            pending <= dec_val;
        end
    end

    // The active duty only moves at the boundary, so the comparator sees a
    // stable value for the whole period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= RST_N;
        end else if (boundary) begin
            active <= pending;
        end
    end

    // active == PERIOD keeps cnt < active true for every count, giving a
    // constant high across the wrap; active == 0 gives a constant low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < active);
        end
    end

endmodule

module pwm_multi_channel #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 4,
    parameter int PERIOD       = 10,
    parameter int DUTY_RESET   = 5,
    parameter int STEP         = 1,
    parameter int DEBOUNCE_DIV = 2,
    parameter int SEL_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic              mode,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [CNT_W-1:0]  duty_o,
    output logic              period_start
);

    localparam int TICK_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);

    // ------------------------------------------------------------------
    // Debounce sample tick
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    // With DEBOUNCE_DIV == 1 the counter sits at 0 and tick is always 1.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce / edge detect
    // ------------------------------------------------------------------
    // s1 samples the raw pin, s2 holds the previous sample. A rising edge
    // between two tick samples yields exactly one event, however long the
    // button stays down.
    logic inc_s1, inc_s2, dec_s1, dec_s2;
    logic ev_inc, ev_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_s1 <= 1'b0;
            inc_s2 <= 1'b0;
            dec_s1 <= 1'b0;
            dec_s2 <= 1'b0;
        end else if (tick) begin
            inc_s1 <= btn_inc;
            inc_s2 <= inc_s1;
            dec_s1 <= btn_dec;
            dec_s2 <= dec_s1;
        end
    end

    assign ev_inc = inc_s1 & ~inc_s2 & tick;
    assign ev_dec = dec_s1 & ~dec_s2 & tick;

    // ------------------------------------------------------------------
    // Shared period counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             dir_down;
    logic             mode_q;
    logic             boundary;

    // Edge mode ends a period at the top count; center mode ends it at the
    // bottom of the down ramp.
    assign boundary = mode_q ? (dir_down && (cnt == '0)) : (cnt == CNT_LAST);

    // Center mode: the top count is repeated by flipping direction without
    // moving, and the bottom count is repeated by the boundary restart at 0,
    // so each endpoint is held for two cycles and the period is 2*PERIOD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dir_down <= 1'b0;
            mode_q   <= 1'b0;
        end else if (boundary) begin
            cnt      <= '0;
            dir_down <= 1'b0;
            mode_q   <= mode;
        end else if (!mode_q) begin
            cnt      <= cnt + 1'b1;
        end else if (!dir_down) begin
            if (cnt == CNT_LAST) begin
                dir_down <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Registered like pwm_out so the pulse lines up with the output cycle
    // produced from count 0 on the up ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == '0) && !dir_down;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][CNT_W-1:0] pending;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = (ch_sel == SEL_W'(i));

        pwm_channel #(
            .CNT_W      (CNT_W),
            .PERIOD     (PERIOD),
            .DUTY_RESET (DUTY_RESET),
            .STEP       (STEP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .inc      (ev_inc & sel),
            .dec      (ev_dec & sel),
            .boundary (boundary),
            .cnt      (cnt),
            .pending  (pending[i]),
            .pwm      (pwm_out[i])
        );
    end

    // An out-of-range ch_sel matches no channel, so events are dropped and
    // duty_o reads 0.
    always_comb begin
        duty_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                duty_o = pending[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Directed bench for pwm_multi_channel (default parameters) plus a second
// 3-channel instance used for the out-of-range channel select case.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn_inc = 1'b0;
    logic             btn_dec = 1'b0;
    logic [2:0]       ch_sel = 3'd0;
    logic             mode = 1'b0;
    logic [NCH-1:0]   pwm_out;
    logic [3:0]       duty_o;
    logic             period_start;

    logic             btn3_inc = 1'b0;
    logic             btn3_dec = 1'b0;
    logic [2:0]       ch_sel3 = 3'd5;
    logic             mode3 = 1'b0;
    logic [2:0]       pwm3;
    logic [3:0]       duty3;
    logic             ps3;

    int checks = 0;
    int failures = 0;

    // Per-period measurement results
    int          per_len;
    int          hi [NCH];
    logic [63:0] pat [NCH];
    logic [3:0]  duty_at5;
    int          ps_wait;

    always #5 clk = ~clk;

    pwm_multi_channel dut (
        .clk          (clk),
        .rst          (rst),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .ch_sel       (ch_sel),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .duty_o       (duty_o),
        .period_start (period_start)
    );

    pwm_multi_channel #(.NUM_CH(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .btn_inc      (btn3_inc),
        .btn_dec      (btn3_dec),
        .ch_sel       (ch_sel3),
        .mode         (mode3),
        .pwm_out      (pwm3),
        .duty_o       (duty3),
        .period_start (ps3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to a falling edge where period_start is high (bounded).
    task automatic wait_ps();
        ps_wait = 0;
        while (!period_start && ps_wait < 100) begin
            @(negedge clk);
            ps_wait++;
        end
        chk("wait_period_start", period_start, 1'b1);
    endtask

    // Called at a falling edge with period_start high; records one period
    // and returns at the falling edge of the next period_start.
    task automatic measure();
        per_len = 0;
        duty_at5 = '0;
        for (int i = 0; i < NCH; i++) begin
            hi[i]  = 0;
            pat[i] = '0;
        end
        do begin
            for (int i = 0; i < NCH; i++) begin
                if (pwm_out[i]) hi[i]++;
                pat[i][per_len] = pwm_out[i];
            end
            if (per_len == 5) duty_at5 = duty_o;
            per_len++;
            @(negedge clk);
        end while (!period_start && per_len < 64);
    endtask

    task automatic press(input bit inc, input bit dec, input bit on3);
        if (on3) btn3_inc = inc;
        else begin
            btn_inc = inc;
            btn_dec = dec;
        end
        repeat (6) @(negedge clk);
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        btn3_inc = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_pwm", pwm_out, 4'h0);
        chk("rst_ps", period_start, 1'b0);
        chk("rst_duty", duty_o, 4'd5);
        rst = 1'b0;

        // ---------------- 1: defaults, 5/10 ----------------
        @(negedge clk);
        chk("t1_first_ps", period_start, 1'b1);
        chk("t1_first_pwm", pwm_out, 4'hF);
        measure();
        chk("t1_len", per_len, 10);
        chk("t1_pat0", pat[0], 64'h1F);
        chk("t1_hi3", hi[3], 5);
        measure();
        chk("t1_len2", per_len, 10);
        chk("t1_duty", duty_o, 4'd5);

        // ---------------- 2: held inc on channel 2 ----------------
        ch_sel  = 3'd2;
        btn_inc = 1'b1;
        measure();
        chk("t2_duty_early", duty_at5, 4'd6);
        chk("t2_inprog_hi2", hi[2], 5);
        measure();
        chk("t2_next_hi2", hi[2], 6);
        chk("t2_pat2", pat[2], 64'h3F);
        chk("t2_hi1", hi[1], 5);
        repeat (20) @(negedge clk);
        btn_inc = 1'b0;
        chk("t2_single_event", duty_o, 4'd6);

        // ---------------- 3: saturation on channel 0 ----------------
        ch_sel = 3'd0;
        repeat (7) press(1'b1, 1'b0, 1'b0);
        chk("t3_sat_hi", duty_o, 4'd10);
        wait_ps();
        measure();
        chk("t3_full_hi0", hi[0], 10);
        measure();
        chk("t3_full_hi0_wrap", hi[0], 10);
        chk("t3_full_len", per_len, 10);
        repeat (12) press(1'b0, 1'b1, 1'b0);
        chk("t3_sat_lo", duty_o, 4'd0);
        wait_ps();
        measure();
        chk("t3_zero_hi0", hi[0], 0);
        chk("t3_hi2_kept", hi[2], 6);

        // ---------------- 4: discarded events ----------------
        ch_sel = 3'd1;
        press(1'b1, 1'b1, 1'b0);
        chk("t4_both", duty_o, 4'd5);
        ch_sel = 3'd5;
        #1 chk("t4_oob_duty", duty_o, 4'd0);
        press(1'b1, 1'b0, 1'b0);
        ch_sel = 3'd0; #1 chk("t4_ch0", duty_o, 4'd0);
        ch_sel = 3'd1; #1 chk("t4_ch1", duty_o, 4'd5);
        ch_sel = 3'd2; #1 chk("t4_ch2", duty_o, 4'd6);
        ch_sel = 3'd3; #1 chk("t4_ch3", duty_o, 4'd5);
        chk("t4_n3_oob_duty", duty3, 4'd0);
        press(1'b1, 1'b0, 1'b1);
        ch_sel3 = 3'd0; #1 chk("t4_n3_ch0", duty3, 4'd5);
        ch_sel3 = 3'd2; #1 chk("t4_n3_ch2", duty3, 4'd5);
        ch_sel3 = 3'd3; #1 chk("t4_n3_ch3", duty3, 4'd0);
        wait_ps();
        chk("t4_n3_ps", ps3, 1'b1);
        chk("t4_n3_pwm", pwm3, 3'b111);

        // ---------------- 5: center mode switch ----------------
        ch_sel = 3'd1;
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("t5_duty3", duty_o, 4'd3);
        wait_ps();
        repeat (4) @(negedge clk);
        mode = 1'b1;
        wait_ps();
        chk("t5_edge_tail", ps_wait, 6);
        measure();
        chk("t5_len", per_len, 20);
        chk("t5_hi1", hi[1], 6);
        chk("t5_pat1", pat[1], 64'h000E_0007);
        chk("t5_hi2", hi[2], 12);
        chk("t5_hi0", hi[0], 0);
        measure();
        chk("t5_len2", per_len, 20);

        // ---------------- 6: asynchronous reset mid-period ----------------
        repeat (5) @(negedge clk);
        chk("t6_pre_pwm", pwm_out, 4'h4);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_pwm", pwm_out, 4'h0);
        chk("t6_async_duty", duty_o, 4'd5);
        chk("t6_async_ps", period_start, 1'b0);
        mode = 1'b0;
        @(negedge clk);
        ch_sel = 3'd0; #1 chk("t6_ch0", duty_o, 4'd5);
        ch_sel = 3'd2; #1 chk("t6_ch2", duty_o, 4'd5);
        @(negedge clk);
        chk("t6_hold_pwm", pwm_out, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ps_after", period_start, 1'b1);
        chk("t6_pwm_after", pwm_out, 4'hF);
        measure();
        chk("t6_len", per_len, 10);
        chk("t6_hi2", hi[2], 5);
        chk("t6_pat1", pat[1], 64'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
